// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline boundary of the 5-stage RV32I core. It registers the decode
// results (register operands, immediate, indices and control bits) into the
// EX slot. It also handles three things at this boundary:
//   - load-use hazard detection, which stalls IF/ID and injects a bubble;
//   - the WB->ID bypass, which covers a register-file write in the same cycle;
//   - the EX redirect flush.
// It keeps a saturating count of injected bubbles for performance debug.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   id_*                          decode-stage instruction fields and control
//   ex_flush                      taken branch/jump redirect from EX
//   wb_reg_write, wb_rd, wb_data  register-file write in progress
//   stall                         combinational hold request for PC and IF/ID
//   ex_*                          registered EX-slot contents
//   bubble_count                  registered saturating bubble counter
//
// Each cycle is either NORMAL (decode captured) or BUBBLE (EX slot cleared).
// A held load-use resolves after exactly one bubble, because the load then
// sits in MEM and the EX forwarding unit covers it.

module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [31:0] id_rdata1,
  input  logic [31:0] id_rdata2,
  input  logic [31:0] id_imm,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        id_alu_src,
  input  logic        id_branch,
  input  logic        id_jump,
  input  logic [3:0]  id_alu_op,
  input  logic [2:0]  id_funct3,
  input  logic        ex_flush,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rdata1,
  output logic [31:0] ex_rdata2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_alu_src,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic [3:0]  ex_alu_op,
  output logic [2:0]  ex_funct3,
  output logic [31:0] bubble_count
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic [31:0] rdata2_q, rdata2_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump}
  logic [6:0]  ctrl_q, ctrl_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] bcnt_q, bcnt_d;

  logic [31:0] op1_byp, op2_byp;
  logic        hazard;

  // Same-cycle WB write. x0 is never bypassed, because it always reads as zero.
  always_comb begin
    op1_byp = id_rdata1;
    op2_byp = id_rdata2;
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1)) op1_byp = wb_data;
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2)) op2_byp = wb_data;
  end

  // The hazard depends only on registered EX state and decode inputs, so there
  // is no path from stall back into it.
  always_comb begin
    hazard = id_valid && valid_q && ctrl_q[5] && (rd_q != 5'd0) &&
             ((id_uses_rs1 && (id_rs1 == rd_q)) ||
              (id_uses_rs2 && (id_rs2 == rd_q)));
    stall  = hazard && !ex_flush;
  end

  always_comb begin
    valid_d  = id_valid;
    pc_d     = id_pc;
    rdata1_d = op1_byp;
    rdata2_d = op2_byp;
    imm_d    = id_imm;
    rs1_d    = id_rs1;
    rs2_d    = id_rs2;
    rd_d     = id_rd;
    ctrl_d   = id_valid ? {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
                           id_alu_src, id_branch, id_jump} : 7'd0;
    alu_op_d = id_alu_op;
    funct3_d = id_funct3;
    bcnt_d   = bcnt_q;
    if (ex_flush || hazard) begin
      valid_d  = 1'b0;
      pc_d     = 32'd0;
      rdata1_d = 32'd0;
      rdata2_d = 32'd0;
      imm_d    = 32'd0;
      rs1_d    = 5'd0;
      rs2_d    = 5'd0;
      rd_d     = 5'd0;
      ctrl_d   = 7'd0;
      alu_op_d = 4'd0;
      funct3_d = 3'd0;
    end
    // A flush takes priority, so the bubble it creates is not counted.
    if (!ex_flush && hazard && (bcnt_q != 32'hFFFF_FFFF)) bcnt_d = bcnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= 32'd0;
      rdata1_q <= 32'd0;
      rdata2_q <= 32'd0;
      imm_q    <= 32'd0;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      rd_q     <= 5'd0;
      ctrl_q   <= 7'd0;
      alu_op_q <= 4'd0;
      funct3_q <= 3'd0;
      bcnt_q   <= 32'd0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
      alu_op_q <= alu_op_d;
      funct3_q <= funct3_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rdata1     = rdata1_q;
  assign ex_rdata2     = rdata2_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = ctrl_q[6];
  assign ex_mem_read   = ctrl_q[5];
  assign ex_mem_write  = ctrl_q[4];
  assign ex_mem_to_reg = ctrl_q[3];
  assign ex_alu_src    = ctrl_q[2];
  assign ex_branch     = ctrl_q[1];
  assign ex_jump       = ctrl_q[0];
  assign ex_alu_op     = alu_op_q;
  assign ex_funct3     = funct3_q;
  assign bubble_count  = bcnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage. Directed vectors are driven on the falling edge.
// Each vector pushes its hand-computed EX-slot contents into a scoreboard.
// A monitor pops one record after every rising edge and compares it.
// The combinational stall output is checked in the same cycle it is driven.

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic [31:0] id_rdata1, id_rdata2, id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        id_alu_src, id_branch, id_jump;
  logic [3:0]  id_alu_op;
  logic [2:0]  id_funct3;
  logic        ex_flush;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_alu_src, ex_branch, ex_jump;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_funct3;
  logic [31:0] bubble_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  ctrl;
    logic [3:0]  alu_op;
    logic [2:0]  f3;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump),
    .id_alu_op(id_alu_op), .id_funct3(id_funct3),
    .ex_flush(ex_flush),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    rst = 1'b0; id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_rdata1 = '0; id_rdata2 = '0; id_imm = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
    id_alu_src = 1'b0; id_branch = 1'b0; id_jump = 1'b0; id_alu_op = '0; id_funct3 = '0;
    ex_flush = 1'b0; wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  // Push the expected EX slot for the next edge. When bub is set, a bubble is
  // expected. Otherwise the current decode fields are expected, with the
  // hand-computed operand values r1/r2.
  task automatic push(input logic bub, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] cnt);
    exp_t e;
    e.valid = 1'b0; e.pc = '0; e.rd1 = '0; e.rd2 = '0; e.imm = '0;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.ctrl = '0; e.alu_op = '0; e.f3 = '0;
    e.cnt = cnt;
    if (!bub) begin
      e.valid = id_valid; e.pc = id_pc; e.rd1 = r1; e.rd2 = r2; e.imm = id_imm;
      e.rs1 = id_rs1; e.rs2 = id_rs2; e.rd = id_rd;
      e.ctrl = id_valid ? {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
                           id_alu_src, id_branch, id_jump} : 7'd0;
      e.alu_op = id_alu_op; e.f3 = id_funct3;
    end
    sb.push_back(e);
  endtask

  task automatic chk_stall(input logic exp);
    #1;
    chk("stall", {31'd0, stall}, {31'd0, exp});
  endtask

  // Decode a load "lw rd, imm(rs1)".
  task automatic load(input logic [31:0] pc, input logic [4:0] rd);
    clr();
    id_valid = 1'b1; id_pc = pc; id_rs1 = 5'd2; id_rd = rd; id_uses_rs1 = 1'b1;
    id_rdata1 = 32'h0000_1000; id_imm = 32'd8; id_reg_write = 1'b1; id_mem_read = 1'b1;
    id_mem_to_reg = 1'b1; id_alu_src = 1'b1; id_funct3 = 3'd2;
  endtask

  // Decode an R-type "add rd, rs1, rs2".
  task automatic add(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2);
    clr();
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_rdata1 = d1; id_rdata2 = d2;
    id_reg_write = 1'b1; id_alu_op = 4'h0;
  endtask

  // Monitor: after each rising edge, compare the DUT against the next record.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_rdata1", ex_rdata1, e.rd1);
        chk("ex_rdata2", ex_rdata2, e.rd2);
        chk("ex_imm", ex_imm, e.imm);
        chk("ex_rs1", {27'd0, ex_rs1}, {27'd0, e.rs1});
        chk("ex_rs2", {27'd0, ex_rs2}, {27'd0, e.rs2});
        chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
        chk("ex_ctrl", {25'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                        ex_alu_src, ex_branch, ex_jump}, {25'd0, e.ctrl});
        chk("ex_alu_op", {28'd0, ex_alu_op}, {28'd0, e.alu_op});
        chk("ex_funct3", {29'd0, ex_funct3}, {29'd0, e.f3});
        chk("bubble_count", bubble_count, e.cnt);
      end
    end
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    // Reset for two cycles with random inputs.
    clr();
    rst = 1'b1;
    id_valid = 1'b1; id_pc = $urandom; id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
    id_rd = 5'($urandom); id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
    id_reg_write = 1'b1; id_mem_read = 1'b1; id_alu_op = 4'($urandom); id_funct3 = 3'($urandom);
    wb_reg_write = 1'b1; wb_rd = 5'($urandom); wb_data = $urandom;
    push(1'b1, 0, 0, 32'd0);
    @(negedge clk);
    id_pc = $urandom; id_rdata1 = $urandom;
    push(1'b1, 0, 0, 32'd0);
    chk_stall(1'b0);

    // Pass-through.
    @(negedge clk); clr();
    id_valid = 1'b1; id_pc = 32'h0000_0040; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
    id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_rdata1 = 32'h0000_1234; id_rdata2 = 32'h55;
    id_imm = 32'hFFFF_FFF0; id_reg_write = 1'b1; id_alu_op = 4'h2;
    push(1'b0, 32'h0000_1234, 32'h55, 32'd0);
    chk_stall(1'b0);

    // lw x5, then a dependent add: one stall and one bubble, then the add.
    @(negedge clk); load(32'h44, 5'd5);
    push(1'b0, 32'h1000, 32'd0, 32'd0);
    chk_stall(1'b0);
    @(negedge clk); add(32'h48, 5'd5, 5'd6, 5'd7, 32'h11, 32'h22);
    push(1'b1, 0, 0, 32'd1);
    chk_stall(1'b1);
    @(negedge clk); add(32'h48, 5'd5, 5'd6, 5'd7, 32'h11, 32'h22);
    push(1'b0, 32'h11, 32'h22, 32'd1);
    chk_stall(1'b0);

    // A load to x0 never causes a hazard.
    @(negedge clk); load(32'h4C, 5'd0);
    push(1'b0, 32'h1000, 32'd0, 32'd1);
    chk_stall(1'b0);
    @(negedge clk); add(32'h50, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0);
    push(1'b0, 32'h0, 32'h0, 32'd1);
    chk_stall(1'b0);

    // rs2 matches the load's rd, but the instruction does not read rs2.
    @(negedge clk); load(32'h54, 5'd9);
    push(1'b0, 32'h1000, 32'd0, 32'd1);
    chk_stall(1'b0);
    @(negedge clk); add(32'h58, 5'd1, 5'd9, 5'd10, 32'h33, 32'h44);
    id_uses_rs2 = 1'b0; id_alu_src = 1'b1;
    push(1'b0, 32'h33, 32'h44, 32'd1);
    chk_stall(1'b0);

    // WB bypass on rs2.
    @(negedge clk); add(32'h5C, 5'd1, 5'd7, 5'd11, 32'h66, 32'h0);
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
    push(1'b0, 32'h66, 32'hDEAD_BEEF, 32'd1);
    chk_stall(1'b0);
    // wb_rd = 0 never bypasses.
    @(negedge clk); add(32'h60, 5'd1, 5'd0, 5'd11, 32'h66, 32'h0);
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
    push(1'b0, 32'h66, 32'h0, 32'd1);
    chk_stall(1'b0);
    // WB bypass on rs1; wb_rd equal only to id_rd has no effect.
    @(negedge clk); add(32'h64, 5'd3, 5'd4, 5'd12, 32'h77, 32'h88);
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'h0BAD_F00D;
    push(1'b0, 32'h0BAD_F00D, 32'h88, 32'd1);
    chk_stall(1'b0);
    @(negedge clk); add(32'h68, 5'd1, 5'd2, 5'd13, 32'hA, 32'hB);
    wb_reg_write = 1'b1; wb_rd = 5'd13; wb_data = 32'hFFFF_0000;
    push(1'b0, 32'hA, 32'hB, 32'd1);
    chk_stall(1'b0);
    // Same bypass value but a write-disabled WB: no bypass.
    @(negedge clk); add(32'h6C, 5'd3, 5'd4, 5'd12, 32'h77, 32'h88);
    wb_reg_write = 1'b0; wb_rd = 5'd3; wb_data = 32'h0BAD_F00D;
    push(1'b0, 32'h77, 32'h88, 32'd1);
    chk_stall(1'b0);

    // A bypass and a hazard in the same cycle: the hazard still bubbles.
    @(negedge clk); load(32'h70, 5'd4);
    push(1'b0, 32'h1000, 32'd0, 32'd1);
    chk_stall(1'b0);
    @(negedge clk); add(32'h74, 5'd4, 5'd1, 5'd14, 32'h1, 32'h2);
    wb_reg_write = 1'b1; wb_rd = 5'd4; wb_data = 32'hCAFE_0000;
    push(1'b1, 0, 0, 32'd2);
    chk_stall(1'b1);
    @(negedge clk); add(32'h74, 5'd4, 5'd1, 5'd14, 32'h1, 32'h2);
    wb_reg_write = 1'b1; wb_rd = 5'd4; wb_data = 32'hCAFE_0000;
    push(1'b0, 32'hCAFE_0000, 32'h2, 32'd2);
    chk_stall(1'b0);

    // A flush together with a hazard: the flush wins and the count is unchanged.
    @(negedge clk); load(32'h78, 5'd8);
    push(1'b0, 32'h1000, 32'd0, 32'd2);
    chk_stall(1'b0);
    @(negedge clk); add(32'h7C, 5'd8, 5'd1, 5'd15, 32'h5, 32'h6);
    ex_flush = 1'b1;
    push(1'b1, 0, 0, 32'd2);
    chk_stall(1'b0);
    // A flush on a valid branch.
    @(negedge clk); add(32'h80, 5'd1, 5'd2, 5'd0, 32'h5, 32'h6);
    id_branch = 1'b1; id_reg_write = 1'b0; ex_flush = 1'b1;
    push(1'b1, 0, 0, 32'd2);
    chk_stall(1'b0);

    // id_valid=0: the fields are captured but the control bits are forced to 0.
    @(negedge clk); add(32'h84, 5'd1, 5'd2, 5'd3, 32'h9, 32'hA);
    id_valid = 1'b0; id_mem_write = 1'b1; id_jump = 1'b1; id_alu_op = 4'h7; id_funct3 = 3'd5;
    push(1'b0, 32'h9, 32'hA, 32'd2);
    chk_stall(1'b0);

    // Reset during a stall clears the stall source.
    @(negedge clk); load(32'h88, 5'd5);
    push(1'b0, 32'h1000, 32'd0, 32'd2);
    chk_stall(1'b0);
    @(negedge clk); add(32'h8C, 5'd5, 5'd1, 5'd6, 32'h3, 32'h4);
    rst = 1'b1;
    push(1'b1, 0, 0, 32'd0);
    chk_stall(1'b1);
    @(negedge clk); add(32'h8C, 5'd5, 5'd1, 5'd6, 32'h3, 32'h4);
    push(1'b0, 32'h3, 32'h4, 32'd0);
    chk_stall(1'b0);

    // Saturation: preload the counter to one below the maximum.
    @(negedge clk);
    force dut.bcnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.bcnt_q;
    load(32'h90, 5'd5);
    push(1'b0, 32'h1000, 32'd0, 32'hFFFF_FFFE);
    @(negedge clk); add(32'h94, 5'd5, 5'd1, 5'd6, 32'h3, 32'h4);
    push(1'b1, 0, 0, 32'hFFFF_FFFF);
    chk_stall(1'b1);
    @(negedge clk); add(32'h94, 5'd5, 5'd1, 5'd6, 32'h3, 32'h4);
    push(1'b0, 32'h3, 32'h4, 32'hFFFF_FFFF);
    chk_stall(1'b0);
    @(negedge clk); load(32'h98, 5'd6);
    push(1'b0, 32'h1000, 32'd0, 32'hFFFF_FFFF);
    chk_stall(1'b0);
    @(negedge clk); add(32'h9C, 5'd1, 5'd6, 5'd7, 32'h3, 32'h4);
    push(1'b1, 0, 0, 32'hFFFF_FFFF);
    chk_stall(1'b1);

    @(negedge clk); clr();
    push(1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline boundary for the 5-stage RV32I core. It captures register-file read data, the decoded immediate and the control bits at the end of decode, and hands them to the execute stage one cycle later. It owns load-use hazard detection, which stalls IF/ID and injects a bubble, and the WB→ID bypass, which covers a same-cycle register-file write. It also honours the EX-resolved branch/jump flush and keeps a saturating bubble counter for performance debug.

## Interface
- No parameters; widths fixed by RV32I (XLEN 32, 5-bit register index).
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  32  PC of decode instruction
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2
- id_rdata1, id_rdata2  in  32 each  register-file read data (x0 already forced to 0)
- id_imm  in  32  sign-extended immediate
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch, id_jump  in  1 each  control bits
- id_alu_op  in  4  ALU operation select
- id_funct3  in  3  passed through for branch/memory sizing
- ex_flush  in  1  EX redirect (taken branch/jump); kill ID and EX contents
- wb_reg_write  in  1  WB stage writes the register file this cycle
- wb_rd  in  5  WB destination
- wb_data  in  32  WB write data
- stall  out  1  combinational; hold PC and IF/ID register
- ex_valid  out  1  registered; EX slot holds a real instruction
- ex_pc, ex_rdata1, ex_rdata2, ex_imm  out  32 each  registered
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered (for EX forwarding unit)
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch, ex_jump  out  1 each  registered
- ex_alu_op  out  4, ex_funct3  out  3  registered
- bubble_count  out  32  registered, saturating count of injected bubbles

## Operation
- Bypass, combinational: bypassed operand1 = wb_data when wb_reg_write && wb_rd != 0 && wb_rd == id_rs1; otherwise id_rdata1. Operand2 is the same with id_rs2. rs index 0 never bypasses.
- Hazard, combinational: hazard = id_valid && ex_valid && ex_mem_read && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)).
- stall = hazard && !ex_flush. The flush kills the decode instruction, so it is never stalled.
- Each clock edge applies exactly one action, in priority order:
  - rst: all ex_* outputs and bubble_count go to 0.
  - ex_flush: EX slot becomes a bubble (ex_valid=0, all control bits 0, data/index fields 0). bubble_count unchanged.
  - hazard: EX slot becomes a bubble as above. bubble_count += 1, saturating at 0xFFFF_FFFF.
  - otherwise: capture all id_* fields and the bypassed operands. ex_valid = id_valid. If id_valid=0, control bits are forced to 0.
- Bubbles never carry reg_write, mem_write, branch or jump, so no architectural side effect can leak.
- States are implicit: NORMAL / BUBBLE per cycle. No multi-cycle FSM; a held load-use resolves after exactly one bubble, because the load then sits in MEM and EX forwarding covers it.

## Timing
- All ex_* outputs and bubble_count are valid one cycle after capture: decode at cycle N appears in EX at N+1.
- stall and the bypass are same-cycle combinational. There is no path from stall back into hazard.
- Load-use costs exactly 1 bubble. Back-to-back dependent loads each cost 1.
- Reset takes effect at the first rising edge with rst=1. rst during a stall clears the stall source (ex_valid=0), so stall drops in the next cycle.
- ex_flush together with hazard: flush wins, stall=0, count unchanged.
- wb_rd == id_rd with no read of it: no effect. A bypass and a hazard in the same cycle: the hazard still bubbles.

## Test plan
- Reset: assert rst for 2 cycles with random inputs → all ex_* = 0, bubble_count = 0, stall = 0.
- Pass-through: id_valid=1, id_pc=0x0000_0040, id_rdata1=0x1234, id_imm=0xFFFF_FFF0, id_reg_write=1, id_alu_op=4'h2 → next cycle ex_pc=0x40, ex_rdata1=0x1234, ex_imm=0xFFFF_FFF0, ex_reg_write=1, ex_valid=1.
- Load-use: lw x5 in EX (ex_mem_read=1, ex_rd=5), decode add with rs1=5 → stall=1 for one cycle, next EX slot ex_valid=0 with all control bits 0, bubble_count=1; following cycle the add is captured.
- No false hazard: ex_rd=0 with ex_mem_read=1, or id_uses_rs2=0 with id_rs2 == ex_rd → stall=0, no bubble.
- WB bypass: wb_reg_write=1, wb_rd=7, wb_data=0xDEAD_BEEF, id_rs2=7, id_rdata2=0 → ex_rdata2=0xDEAD_BEEF. Repeat with wb_rd=0 → ex_rdata2=0.
- Flush versus hazard: same cycle as a load-use hazard, assert ex_flush=1 → stall=0, EX bubble, bubble_count unchanged. Also preload bubble_count to 0xFFFF_FFFF and trigger a hazard → count stays 0xFFFF_FFFF.
